// File: rtl/fp_div_seq.sv
// -----------------------------------------------------------------------------
// fp_div_seq
//   Sequential single-precision IEEE-754 divider, X3 = X1 / X2, used as the
//   FDIV functional unit behind a reservation station. The quotient mantissa
//   comes from a restoring divider that retires one bit per cycle. The result
//   is truncated (round toward zero), and it never produces a subnormal output.
//
//   Handshake: start is sampled only in IDLE. busy is high in every other
//   state. done is a one-cycle pulse. X3 and tag_out are valid while done is
//   high and hold their values until the next result load.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   start    in   operation request (ignored unless idle)
//   X1       in   [31:0] dividend
//   X2       in   [31:0] divisor
//   tag_in   in   [TAG_W-1:0] reservation-station tag captured with operands
//   busy     out  high whenever the unit is not idle
//   done     out  one-cycle completion pulse
//   X3       out  [31:0] quotient
//   tag_out  out  [TAG_W-1:0] tag belonging to X3
// -----------------------------------------------------------------------------
module fp_div_seq #(
    parameter int TAG_W = 4,
    parameter int QBITS = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      X1,
    input  logic [31:0]      X2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [31:0]      X3,
    output logic [TAG_W-1:0] tag_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [4:0] LAST_COUNT = 5'(QBITS - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [QBITS-1:0]   r_q;
    logic [4:0]         r_count;
    logic [7:0]         r_e1;
    logic [7:0]         r_e2;
    logic               r_sign;
    logic [TAG_W-1:0]   r_tag;

    // ---------------------------------------------------------------------
    // Operand classification, evaluated on the live inputs in IDLE
    // ---------------------------------------------------------------------
    logic               w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
    logic               w_special;
    logic [31:0]        w_special_val;

    always_comb begin
        w_zero1 = (X1[30:0] == 31'd0);
        w_zero2 = (X2[30:0] == 31'd0);
        w_inf1  = (X1[30:23] == 8'hFF) && (X1[22:0] == 23'd0);
        w_inf2  = (X2[30:23] == 8'hFF) && (X2[22:0] == 23'd0);
        w_nan1  = (X1[30:23] == 8'hFF) && (X1[22:0] != 23'd0);
        w_nan2  = (X2[30:23] == 8'hFF) && (X2[22:0] != 23'd0);

        w_special     = 1'b1;
        w_special_val = 32'h0000_0000;
        // Priority order matters: 0/0 and Inf/Inf must win over the
        // single-operand rules below them. The sign is never applied here.
        if (w_nan1 || w_nan2 || (w_inf1 && w_inf2) || (w_zero1 && w_zero2)) begin
            w_special_val = 32'h7FFF_FFFF;
        end else if (w_inf1 || w_zero2) begin
            w_special_val = 32'h7F80_0000;
        end else if (w_zero1 || w_inf2) begin
            w_special_val = 32'h0000_0000;
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // One restoring-division step. After the subtraction the remainder is
    // below the 24-bit divisor, so the shift stays inside 26 bits.
    // ---------------------------------------------------------------------
    logic               w_ge;
    logic [25:0]        w_rem_sub;
    logic [25:0]        w_rem_next;

    always_comb begin
        w_ge       = (r_rem >= {2'b00, r_div});
        w_rem_sub  = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;
        w_rem_next = w_rem_sub << 1;
    end

    // ---------------------------------------------------------------------
    // Normalisation. The quotient lies in [0.5, 2), so at most one bit of
    // left shift is needed. The exponent is signed so that underflow shows
    // up as a value <= 0.
    // ---------------------------------------------------------------------
    logic signed [9:0]  w_exp;
    logic [22:0]        w_mant;
    logic [31:0]        w_norm_val;

    always_comb begin
        w_exp      = $signed({2'b00, r_e1}) - $signed({2'b00, r_e2})
                   + (r_q[QBITS-1] ? 10'sd127 : 10'sd126);
        w_mant     = r_q[QBITS-1] ? r_q[23:1] : r_q[22:0];
        w_norm_val = {r_sign, w_exp[7:0], w_mant};
        if (w_exp >= 10'sd255) begin
            w_norm_val = 32'h7F80_0000;
        end else if (w_exp <= 10'sd0) begin
            w_norm_val = 32'h0000_0000;
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_special ? S_DONE : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_count == LAST_COUNT) begin
                    w_next_state = S_NORM;
                end
            end
            S_NORM:  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_count <= '0;
            r_e1    <= '0;
            r_e2    <= '0;
            r_sign  <= 1'b0;
            r_tag   <= '0;
            X3      <= '0;
            tag_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign  <= X1[31] ^ X2[31];
                        r_e1    <= X1[30:23];
                        r_e2    <= X2[30:23];
                        r_tag   <= tag_in;
                        // Subnormal inputs are given a hidden 1 as well.
                        r_rem   <= {2'b01, X1[22:0]};
                        r_div   <= {1'b1, X2[22:0]};
                        r_q     <= '0;
                        r_count <= '0;
                        if (w_special) begin
                            X3      <= w_special_val;
                            tag_out <= tag_in;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_q     <= {r_q[QBITS-2:0], w_ge};
                    r_rem   <= w_rem_next;
                    r_count <= r_count + 5'd1;
                end
                S_NORM: begin
                    X3      <= w_norm_val;
                    tag_out <= r_tag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_div_seq
//   Directed and randomised checks of fp_div_seq. Expected quotients come from
//   a truncating reference computed with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fp_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] X1;
  logic [31:0] X2;
  logic [3:0]  tag_in;
  logic        busy;
  logic        done;
  logic [31:0] X3;
  logic [3:0]  tag_out;

  int n_cmp;
  int n_fail;

  fp_div_seq #(.TAG_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .X1      (X1),
    .X2      (X2),
    .tag_in  (tag_in),
    .busy    (busy),
    .done    (done),
    .X3      (X3),
    .tag_out (tag_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: {special, result}
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        za, zb, ia, ib, na, nb;
    longint      num, den, q, mant;
    int          e;
    logic [31:0] r;
    ea = a[30:23]; eb = b[30:23];
    ma = a[22:0];  mb = b[22:0];
    za = (a[30:0] == 31'd0);
    zb = (b[30:0] == 31'd0);
    ia = (ea == 8'hFF) && (ma == 23'd0);
    ib = (eb == 8'hFF) && (mb == 23'd0);
    na = (ea == 8'hFF) && (ma != 23'd0);
    nb = (eb == 8'hFF) && (mb != 23'd0);
    if (na || nb || (ia && ib) || (za && zb)) return {1'b1, 32'h7FFFFFFF};
    if (ia || zb) return {1'b1, 32'h7F800000};
    if (za || ib) return {1'b1, 32'h00000000};
    num = (longint'(ma) + 64'sd8388608) * 64'sd16777216;
    den = longint'(mb) + 64'sd8388608;
    q   = num / den;
    e   = int'(ea) - int'(eb) + 127;
    if (q >= 64'sd16777216) begin
      mant = q / 2;
    end else begin
      mant = q;
      e    = e - 1;
    end
    if (e >= 255) return {1'b0, 32'h7F800000};
    if (e <= 0)   return {1'b0, 32'h00000000};
    r = {a[31] ^ b[31], 8'(e), mant[22:0]};
    return {1'b0, r};
  endfunction

  // driver: one operation, optional start poke while busy, optional reset
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        input logic [31:0] exp_x3, input int exp_lat,
                        input int poke_cyc, input int rst_cyc);
    int n;
    int busy_cnt;
    logic seen;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    X1 = a; X2 = b; tag_in = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    X1 = $urandom; X2 = $urandom; tag_in = 4'($urandom);
    n = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && n <= 60) begin
      if (rst_cyc == n) begin
        #2 reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_x3", X3, 32'd0);
        check("rst_tag", {28'd0, tag_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        check("x3", X3, exp_x3);
        check("tag_out", {28'd0, tag_out}, {28'd0, t});
        check("latency", n, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
      end else begin
        if (poke_cyc == n) begin
          start = 1'b1; X1 = 32'h3F800000; X2 = 32'h40400000; tag_in = ~t;
        end
        n++;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (!seen) check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic run_rand(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = ref_div(a, b);
    run_op(a, b, 4'($urandom), m[31:0], m[32] ? 1 : 27, 0, 0);
  endtask

  // stimulus
  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; X1 = '0; X2 = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_x3", X3, 32'd0);
    check("reset_tag", {28'd0, tag_out}, 32'd0);
    reset = 1'b0;

    // main function
    run_op(32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 27, 0, 0);
    run_op(32'h3F800000, 32'h40400000, 4'd5, 32'h3EAAAAAA, 27, 0, 0);
    run_op(32'hBFC00000, 32'h3F000000, 4'd9, 32'hC0400000, 27, 0, 0);

    // specials
    run_op(32'h00000000, 32'h00000000, 4'd1, 32'h7FFFFFFF, 1, 0, 0);
    run_op(32'h3F800000, 32'h00000000, 4'd2, 32'h7F800000, 1, 0, 0);
    run_op(32'h00000000, 32'h40000000, 4'd4, 32'h00000000, 1, 0, 0);
    run_op(32'h7FC00000, 32'h3F800000, 4'd6, 32'h7FFFFFFF, 1, 0, 0);
    run_op(32'h7F800000, 32'h7F800000, 4'd7, 32'h7FFFFFFF, 1, 0, 0);
    run_op(32'hFF800000, 32'h40000000, 4'd8, 32'h7F800000, 1, 0, 0);
    run_op(32'hC0000000, 32'h7F800000, 4'd10, 32'h00000000, 1, 0, 0);

    // range limits
    run_op(32'h7F000000, 32'h00800000, 4'd11, 32'h7F800000, 27, 0, 0);
    run_op(32'h00800000, 32'h7F000000, 4'd12, 32'h00000000, 27, 0, 0);

    // start while busy is ignored
    run_op(32'h40C00000, 32'h40000000, 4'd13, 32'h40400000, 27, 10, 0);

    // asynchronous reset mid-division, then recovery
    run_op(32'h40C00000, 32'h40000000, 4'd14, 32'h40400000, 27, 0, 12);
    run_op(32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 27, 0, 0);

    // randomised normal operands
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
      if (i < 20) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      run_rand(a, b);
    end

    @(negedge clk);
    check("final_done", {31'd0, done}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
